// File: rtl/risc_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : risc_cpu_pkg
// Description : Shared CPU widths, opcode encodings and instruction-assembler
//               state type.
// Revision    : 1.0 - initial release
// ============================================================================
package risc_cpu_pkg;

  localparam int c_BUS_W   = 8;
  localparam int c_INSTR_W = 16;
  localparam int c_OPC_W   = 3;

  localparam logic [c_OPC_W-1:0] c_OPC_HLT = 3'b000;
  localparam logic [c_OPC_W-1:0] c_OPC_SKZ = 3'b001;
  localparam logic [c_OPC_W-1:0] c_OPC_ADD = 3'b010;
  localparam logic [c_OPC_W-1:0] c_OPC_AND = 3'b011;
  localparam logic [c_OPC_W-1:0] c_OPC_XOR = 3'b100;
  localparam logic [c_OPC_W-1:0] c_OPC_LDA = 3'b101;
  localparam logic [c_OPC_W-1:0] c_OPC_STO = 3'b110;
  localparam logic [c_OPC_W-1:0] c_OPC_JMP = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } asm_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_reg_asm_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_reg_asm_if
// Description : Beat-load request bus and assembled-instruction outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_reg_asm_if
  import risc_cpu_pkg::*;
#(
  parameter int BUS_W   = c_BUS_W,
  parameter int INSTR_W = c_INSTR_W,
  parameter int OPC_W   = c_OPC_W
);

  localparam int c_BEATS = INSTR_W / BUS_W;
  localparam int c_IDX_W = $clog2(c_BEATS);

  logic                     ena;
  logic                     flush;
  logic [BUS_W-1:0]         data;
  logic [INSTR_W-1:0]       instr;
  logic [OPC_W-1:0]         opcode;
  logic [INSTR_W-OPC_W-1:0] ir_addr;
  logic                     instr_valid;
  logic                     abort;
  logic                     busy;
  logic [c_IDX_W-1:0]       beat_idx;

  modport master (
    output ena, flush, data,
    input  instr, opcode, ir_addr, instr_valid, abort, busy, beat_idx
  );

  modport slave (
    input  ena, flush, data,
    output instr, opcode, ir_addr, instr_valid, abort, busy, beat_idx
  );

endinterface
`default_nettype wire

// File: rtl/instr_reg_asm.sv
`default_nettype none
// ============================================================================
// Module      : instr_reg_asm
// Description : Assembles a wide instruction from MSB-first bus beats in a
//               shadow buffer and publishes it atomically on the last beat.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_reg_asm
  import risc_cpu_pkg::*;
#(
  parameter int BUS_W   = c_BUS_W,
  parameter int INSTR_W = c_INSTR_W,
  parameter int OPC_W   = c_OPC_W
) (
  input  logic           clk,
  input  logic           rst,
  instr_reg_asm_if.slave bus
);

  localparam int c_BEATS = INSTR_W / BUS_W;
  localparam int c_IDX_W = $clog2(c_BEATS);

  if ((INSTR_W % BUS_W != 0) || (c_BEATS < 2)) begin : g_param_check
    $error("instr_reg_asm: INSTR_W must be a multiple of BUS_W with at least two beats");
  end

  asm_state_t           r_state, w_state_nx;
  logic [c_IDX_W-1:0]   r_idx, w_idx_nx;
  logic [INSTR_W-1:0]   r_shadow, w_shadow_nx;
  logic [INSTR_W-1:0]   r_instr, w_instr_nx;
  logic                 r_valid, w_valid_nx;
  logic                 r_abort, w_abort_nx;
  logic [INSTR_W-1:0]   w_merged;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_shadow <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_idx    <= w_idx_nx;
      r_shadow <= w_shadow_nx;
      r_instr  <= w_instr_nx;
      r_valid  <= w_valid_nx;
      r_abort  <= w_abort_nx;
    end
  end

  always_comb begin
    // Shadow with the current beat dropped into its slot; the final beat is
    // merged here too so instr can be loaded on the same edge.
    w_merged = r_shadow;
    for (int k = 0; k < c_BEATS; k++) begin
      if (r_idx == c_IDX_W'(k)) begin
        w_merged[INSTR_W-1-k*BUS_W -: BUS_W] = bus.data;
      end
    end

    w_state_nx  = r_state;
    w_idx_nx    = r_idx;
    w_shadow_nx = r_shadow;
    w_instr_nx  = r_instr;
    w_valid_nx  = 1'b0;
    w_abort_nx  = 1'b0;

    if (bus.flush) begin
      w_state_nx = ST_IDLE;
      w_idx_nx   = '0;
      w_abort_nx = (r_state == ST_FILL);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.ena) begin
            w_shadow_nx = w_merged;
            w_idx_nx    = c_IDX_W'(1);
            w_state_nx  = ST_FILL;
          end
        end
        ST_FILL: begin
          if (!bus.ena) begin
            w_state_nx = ST_IDLE;
            w_idx_nx   = '0;
            w_abort_nx = 1'b1;
          end else if (r_idx == c_IDX_W'(c_BEATS - 1)) begin
            w_instr_nx = w_merged;
            w_valid_nx = 1'b1;
            w_state_nx = ST_IDLE;
            w_idx_nx   = '0;
          end else begin
            w_shadow_nx = w_merged;
            w_idx_nx    = r_idx + c_IDX_W'(1);
          end
        end
        default: begin
          w_state_nx = ST_IDLE;
          w_idx_nx   = '0;
        end
      endcase
    end
  end

  assign bus.instr       = r_instr;
  assign bus.opcode      = r_instr[INSTR_W-1 -: OPC_W];
  assign bus.ir_addr     = r_instr[INSTR_W-OPC_W-1:0];
  assign bus.instr_valid = r_valid;
  assign bus.abort       = r_abort;
  assign bus.busy        = (r_state == ST_FILL);
  assign bus.beat_idx    = r_idx;

endmodule
`default_nettype wire
